// File: rtl/osr_if.sv
// osr_if: instruction, TX FIFO and result signals between a PIO state machine and its output shift register.
interface osr_if;
    logic        penable;
    logic        stalled;
    logic [31:0] din;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [31:0] x_default;
    logic [4:0]  shift;
    logic        dir;
    logic        do_shift;
    logic        pull;
    logic        block;
    logic        if_empty;
    logic        set;
    logic        autopull;
    logic [4:0]  pull_thresh;
    logic [31:0] dout;
    logic        osr_stall;
    logic [5:0]  shift_count;
    modport master (
        output penable, stalled, din, fifo_empty, x_default, shift, dir, do_shift,
               pull, block, if_empty, set, autopull, pull_thresh,
        input  fifo_pop, dout, osr_stall, shift_count
    );
    modport slave (
        input  penable, stalled, din, fifo_empty, x_default, shift, dir, do_shift,
               pull, block, if_empty, set, autopull, pull_thresh,
        output fifo_pop, dout, osr_stall, shift_count
    );
endinterface

// File: rtl/osr.sv
// osr: PIO output shift register with OUT, PULL, MOV and autopull handling.
// Define OSR_EAGER_REFILL_EN to let idle cycles refill an exhausted OSR from the TX FIFO.
module osr #(
    parameter bit RESET_EMPTY = 1'b1
) (
    input logic clk,
    input logic reset_n,
    osr_if.slave bus
);
    logic [31:0] r_sr;
    logic [5:0]  r_count;
    logic        w_en;
    logic [5:0]  w_shift_val;
    logic [5:0]  w_thresh;
    logic        w_need;
    logic        w_refill;
    logic        w_sh_stall;
    logic        w_noop;
    logic [31:0] w_src;
    logic [5:0]  w_base;
    logic [31:0] w_mask;
    logic [6:0]  w_sum;
    logic [5:0]  w_cnt_sh;
    logic [31:0] w_sr_sh;
    logic [31:0] w_dout_sh;
    logic [31:0] w_sr_nxt;
    logic [5:0]  w_cnt_nxt;
    logic        w_pop;

    assign w_en        = reset_n && bus.penable && !bus.stalled;
    assign w_shift_val = (bus.shift == 5'd0) ? 6'd32 : {1'b0, bus.shift};
    assign w_thresh    = (bus.pull_thresh == 5'd0) ? 6'd32 : {1'b0, bus.pull_thresh};
    assign w_need      = bus.autopull && (r_count >= w_thresh);
    assign w_refill    = w_need && !bus.fifo_empty;
    assign w_sh_stall  = w_need && bus.fifo_empty;
    assign w_noop      = bus.if_empty && (r_count < w_thresh);

    // Autopull refill feeds the OUT directly from the FIFO head, so there is no extra cycle.
    assign w_src     = w_refill ? bus.din : r_sr;
    assign w_base    = w_refill ? 6'd0 : r_count;
    assign w_mask    = 32'((33'd1 << w_shift_val) - 33'd1);
    assign w_sum     = {1'b0, w_base} + {1'b0, w_shift_val};
    assign w_cnt_sh  = (w_sum > 7'd32) ? 6'd32 : w_sum[5:0];
    assign w_sr_sh   = bus.dir ? (w_src >> w_shift_val) : (w_src << w_shift_val);
    assign w_dout_sh = bus.dir ? (w_src & w_mask) : (w_src >> (6'd32 - w_shift_val));

    assign bus.dout = (bus.do_shift && !bus.set && !bus.pull && !w_sh_stall) ? w_dout_sh : 32'd0;
    assign bus.osr_stall = bus.penable && !bus.set &&
        (bus.pull ? (!w_noop && bus.fifo_empty && bus.block) : (bus.do_shift && w_sh_stall));
    assign bus.fifo_pop    = w_en && w_pop;
    assign bus.shift_count = r_count;

    always_comb begin
        w_sr_nxt  = r_sr;
        w_cnt_nxt = r_count;
        w_pop     = 1'b0;
        if (bus.set) begin
            w_sr_nxt  = bus.din;
            w_cnt_nxt = 6'd0;
        end else if (bus.pull) begin
            if (!w_noop && !bus.fifo_empty) begin
                w_pop     = 1'b1;
                w_sr_nxt  = bus.din;
                w_cnt_nxt = 6'd0;
            end else if (!w_noop && !bus.block) begin
                w_sr_nxt  = bus.x_default;
                w_cnt_nxt = 6'd0;
            end
        end else if (bus.do_shift) begin
            if (!w_sh_stall) begin
                w_pop     = w_refill;
                w_sr_nxt  = w_sr_sh;
                w_cnt_nxt = w_cnt_sh;
            end
`ifdef OSR_EAGER_REFILL_EN
        end else if (w_refill) begin
            w_pop     = 1'b1;
            w_sr_nxt  = bus.din;
            w_cnt_nxt = 6'd0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sr    <= 32'd0;
            r_count <= RESET_EMPTY ? 6'd32 : 6'd0;
        end else if (w_en) begin
            r_sr    <= w_sr_nxt;
            r_count <= w_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_osr.sv
// tb_osr: directed scoreboard bench for osr; expected outputs are queued per cycle and checked by a monitor.
module tb_osr;
    logic clk;
    logic reset_n;
    osr_if bus ();

    osr #(.RESET_EMPTY(1'b1)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] d;
        logic        p;
        logic        s;
        logic [5:0]  c;
    } exp_t;

    exp_t exp_q[$];
    logic tb_v = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;

    // Monitor: the bench marks each checked cycle valid; outputs are sampled mid-cycle.
    always @(negedge clk) begin
        if (tb_v) begin
            if (exp_q.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL scoreboard_empty: output presented with no expectation queued");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_run++;
                if (bus.dout !== e.d || bus.fifo_pop !== e.p || bus.osr_stall !== e.s || bus.shift_count !== e.c) begin
                    n_fail++;
                    $display("FAIL %s: got dout=%h pop=%b stall=%b count=%0d, want dout=%h pop=%b stall=%b count=%0d",
                             e.nm, bus.dout, bus.fifo_pop, bus.osr_stall, bus.shift_count, e.d, e.p, e.s, e.c);
                end
            end
        end
    end

    task automatic cyc(input string nm, input logic [31:0] d, input logic p, input logic s, input logic [5:0] c);
        exp_t e;
        e.nm = nm; e.d = d; e.p = p; e.s = s; e.c = c;
        exp_q.push_back(e);
        tb_v = 1'b1;
        @(posedge clk);
        #1;
        tb_v = 1'b0;
    endtask

    task automatic idle();
        bus.set = 0; bus.pull = 0; bus.do_shift = 0;
        bus.block = 0; bus.if_empty = 0;
    endtask

    task automatic out(input logic d, input logic [4:0] sh);
        idle();
        bus.do_shift = 1; bus.dir = d; bus.shift = sh;
    endtask

    task automatic pull(input logic blk, input logic ife);
        idle();
        bus.pull = 1; bus.block = blk; bus.if_empty = ife;
    endtask

    initial begin
        reset_n = 0;
        bus.penable = 1; bus.stalled = 0; bus.din = 0; bus.fifo_empty = 1;
        bus.x_default = 0; bus.shift = 0; bus.dir = 0; bus.autopull = 0; bus.pull_thresh = 0;
        idle();
        @(posedge clk);
        #1;
        cyc("reset", 32'h0, 0, 0, 6'd32);
        reset_n = 1;
        cyc("post_reset_hold", 32'h0, 0, 0, 6'd32);

        idle(); bus.set = 1; bus.din = 32'hDEADBEEF;
        cyc("set_a", 32'h0, 0, 0, 6'd32);
        out(1, 5'd8);
        cyc("out_r8_first", 32'h000000EF, 0, 0, 6'd0);
        cyc("out_r8_second", 32'h000000BE, 0, 0, 6'd8);
        out(0, 5'd0);
        cyc("out_l32_residue", 32'h0000DEAD, 0, 0, 6'd16);
        idle();
        cyc("count_saturated", 32'h0, 0, 0, 6'd32);

        idle(); bus.set = 1; bus.din = 32'hDEADBEEF;
        cyc("set_b", 32'h0, 0, 0, 6'd32);
        out(0, 5'd4);
        cyc("out_l4", 32'h0000000D, 0, 0, 6'd0);
        out(0, 5'd0);
        cyc("out_l32", 32'hEADBEEF0, 0, 0, 6'd4);
        idle();
        cyc("count_sat_l", 32'h0, 0, 0, 6'd32);

        idle(); bus.set = 1; bus.din = 32'hCAFEF00D;
        cyc("set_c", 32'h0, 0, 0, 6'd32);
        out(1, 5'd16);
        cyc("out_r16", 32'h0000F00D, 0, 0, 6'd0);
        bus.autopull = 1; bus.pull_thresh = 5'd16; bus.fifo_empty = 1;
        out(1, 5'd4);
        cyc("autopull_stall", 32'h0, 0, 1, 6'd16);
        bus.fifo_empty = 0; bus.din = 32'h12345678;
        cyc("autopull_refill", 32'h00000008, 1, 0, 6'd16);
        bus.stalled = 1;
        cyc("stalled_hold", 32'h00000007, 0, 0, 6'd4);
        bus.stalled = 0;
        idle();
        cyc("after_stalled", 32'h0, 0, 0, 6'd4);

        bus.autopull = 0; bus.fifo_empty = 1; bus.x_default = 32'hA5A5A5A5;
        pull(0, 0);
        cyc("pull_nonblock_empty", 32'h0, 0, 0, 6'd4);
        out(1, 5'd8);
        cyc("out_xdefault", 32'h000000A5, 0, 0, 6'd0);
        pull(1, 0);
        cyc("pull_block_empty", 32'h0, 0, 1, 6'd8);
        bus.penable = 0;
        cyc("pull_block_disabled", 32'h0, 0, 0, 6'd8);
        bus.penable = 1; bus.fifo_empty = 0; bus.din = 32'h11111111;
        pull(0, 1);
        cyc("pull_ifempty_noop", 32'h0, 0, 0, 6'd8);
        out(1, 5'd8);
        cyc("out_after_noop", 32'h000000A5, 0, 0, 6'd8);
        bus.din = 32'h0F0F1234;
        pull(1, 0);
        cyc("pull_pop", 32'h0, 1, 0, 6'd16);
        out(1, 5'd16);
        cyc("out_pulled", 32'h00001234, 0, 0, 6'd0);

        bus.autopull = 1; bus.pull_thresh = 5'd0;
        out(0, 5'd0);
        cyc("out_drain", 32'h00000F0F, 0, 0, 6'd16);
        idle(); bus.din = 32'h55AA55AA; bus.stalled = 1;
        cyc("idle_stalled_no_pop", 32'h0, 0, 0, 6'd32);
        bus.stalled = 0;
`ifdef OSR_EAGER_REFILL_EN
        cyc("idle_eager_pop", 32'h0, 1, 0, 6'd32);
        cyc("idle_after_eager", 32'h0, 0, 0, 6'd0);
        out(1, 5'd8);
        cyc("out_after_eager", 32'h000000AA, 0, 0, 6'd0);
`else
        cyc("idle_no_pop", 32'h0, 0, 0, 6'd32);
        cyc("idle_still_empty", 32'h0, 0, 0, 6'd32);
        out(1, 5'd8);
        cyc("out_autopull_zero_lat", 32'h000000AA, 1, 0, 6'd32);
`endif
        idle();
        cyc("final_count", 32'h0, 0, 0, 6'd8);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_run++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/osr.md
Name: osr

Overview:
- PIO output shift register, the transmit-side counterpart of the state machine's input shift register.
- Holds a 32-bit word pulled from the TX FIFO and feeds OUT instructions 1–32 bits at a time, left or right.
- Tracks the output shift count, and handles explicit PULL (blocking, non-blocking, if-empty) and autopull against a programmable threshold.
- Generates the TX FIFO pop and the instruction stall request.

Parameters:
RESET_EMPTY, 1, 1: reset count = 32 (OSR empty); 0: reset count = 0 (OSR full of zeros)

Ports:
clk  input  1  clock
reset_n  input  1  synchronous active-low reset
penable  input  1  state machine enabled; all state changes gated by it
stalled  input  1  external stall (e.g. delay or other unit); holds all state
din  input  32  TX FIFO head data
fifo_empty  input  1  TX FIFO empty
fifo_pop  output  1  pop TX FIFO this cycle
x_default  input  32  scratch X, loaded by non-blocking PULL on empty FIFO
shift  input  5  OUT bit count; 0 means 32
dir  input  1  1 = shift right (LSBs out first), 0 = shift left (MSBs out first)
do_shift  input  1  OUT instruction this cycle
pull  input  1  PULL instruction this cycle
block  input  1  PULL blocks on empty FIFO
if_empty  input  1  PULL is a no-op unless count >= threshold
set  input  1  MOV to OSR: load din, count = 0
autopull  input  1  autopull enable
pull_thresh  input  5  autopull threshold; 0 means 32
dout  output  32  OUT data, right-aligned, zero-extended
osr_stall  output  1  current instruction must stall (combinational)
shift_count  output  6  current count, 0..32

Behaviour:
- State: shift_reg[31:0]; count[5:0], saturating at 32.
- Reset (reset_n low at clk edge): shift_reg = 0; count = 32 if RESET_EMPTY else 0. Overrides everything, including mid-refill.
- shift_val = (shift == 0) ? 32 : shift. thresh = (pull_thresh == 0) ? 32 : pull_thresh. need = autopull && count >= thresh.
- Update only when penable && !stalled && reset_n high. Otherwise hold all state; fifo_pop = 0. dout and osr_stall still evaluate combinationally.
- Priority: set > pull > do_shift > eager refill.
- set: shift_reg = din; count = 0; no pop (the data is supplied by the caller).
- pull:
  - if_empty && count < thresh: no-op.
  - FIFO non-empty: fifo_pop = 1; shift_reg = din; count = 0.
  - FIFO empty && block: osr_stall = 1; no change.
  - FIFO empty && !block: shift_reg = x_default; count = 0.
- do_shift, source word:
  - src = din, with fifo_pop = 1, when need && !fifo_empty (refill and shift in the same cycle, zero latency).
  - need && fifo_empty: osr_stall = 1; no shift; dout = 0.
  - Otherwise src = shift_reg, base count = count.
- do_shift, output and update:
  - dir = 1: dout = src & ((1 << shift_val) - 1); shift_reg = src >> shift_val.
  - dir = 0: dout = src >> (32 - shift_val); shift_reg = src << shift_val.
  - Vacated bits fill with 0. Shift by 32 yields 0.
  - count = min(base + shift_val, 32), where base = 0 if refilled, else count.
- Without autopull, OUT on an empty OSR still shifts and outputs zeros; count stays 32.
- dout = 0 when do_shift is low.
- shift_count = count as registered (no early lookahead).
- osr_stall is asserted only while penable is high. It does not depend on the stalled input.
- At most one fifo_pop per cycle. A pop never occurs when fifo_empty = 1.

Optional Feature:
OSR_EAGER_REFILL_EN
- Defined: in an enabled, unstalled cycle with no set, pull or do_shift, if need && !fifo_empty, then fifo_pop = 1, shift_reg = din, count = 0. The next OUT does not wait on the FIFO.
- Undefined: refill happens only as part of OUT or PULL. An idle cycle never pops.

Test Plan:
- Reset with RESET_EMPTY=1 -> shift_count=32, dout=0, fifo_pop=0. After reset_n rises, state is unchanged until an instruction arrives.
- set din=0xDEADBEEF; then OUT dir=1 shift=8 twice -> dout=0xEF then 0xBE; shift_count 8 then 16; shift_reg=0x0000DEAD.
- set 0xDEADBEEF; OUT dir=0 shift=4 -> dout=0xD, shift_reg=0xEADBEEF0. Then OUT shift=0 -> dout=0xEADBEEF0, count=32 (saturates).
- autopull=1, pull_thresh=16, count=16, fifo_empty=1, OUT -> osr_stall=1, no change. Next cycle fifo_empty=0, din=0x12345678, OUT dir=1 shift=4 -> fifo_pop=1, dout=0x8, count=4.
- pull block=0 with fifo_empty=1, x_default=0xA5A5A5A5 -> shift_reg=0xA5A5A5A5, count=0, no pop. pull block=1 empty -> osr_stall=1. pull if_empty=1 with count=8<thresh=16 -> no pop, no change.
- OSR_EAGER_REFILL_EN defined, autopull on, count=32, FIFO non-empty, idle cycle -> fifo_pop=1, count=0. With the macro undefined -> no pop. stalled=1 in either build -> no pop.
